// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the word-copy bus initiator and its load/store neighbours.
package mem_copy_engine_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } copy_state_t;

   // One 32-bit word spans 8 nibble cells in the data memory.
   localparam int WORD_STRIDE = 8;

endpackage

// File: rtl/mem_copy_engine.sv
// Copies a run of words from src to dst, one read cycle then one write cycle per
// word, in ascending address order.
module mem_copy_engine
   import mem_copy_engine_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 4,
   parameter int STRIDE = WORD_STRIDE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   input  logic [CNT_W-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] address,
   output logic [31:0]       write_data,
   output logic              memoryread,
   output logic              memorywrite,
   input  logic [31:0]       read_data
);

   copy_state_t       state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [31:0]       hold_q, hold_d;

   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      hold_d  = hold_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (count != '0) begin
                  src_d   = src_base;
                  dst_d   = dst_base;
                  rem_d   = count;
                  state_d = READ;
               end else begin
                  state_d = DONE;
               end
            end
         end
         READ: begin
            hold_d  = read_data;
            state_d = WRITE;
         end
         WRITE: begin
            src_d   = src_q + ADDR_W'(STRIDE);
            dst_d   = dst_q + ADDR_W'(STRIDE);
            rem_d   = rem_q - CNT_W'(1);
            state_d = (rem_q == CNT_W'(1)) ? DONE : READ;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Only the state register needs reset; the datapath is don't-care in IDLE.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
      src_q  <= src_d;
      dst_q  <= dst_d;
      rem_q  <= rem_d;
      hold_q <= hold_d;
   end

   // Memory port is decoded from registered state only; reset gates a write in flight.
   always_comb begin
      busy        = (state_q != IDLE);
      done        = (state_q == DONE);
      memoryread  = (state_q == READ);
      memorywrite = (state_q == WRITE) && !reset;
      address     = '0;
      write_data  = '0;
      if (state_q == READ) begin
         address = src_q;
      end else if (state_q == WRITE) begin
         address    = dst_q;
         write_data = hold_q;
      end
   end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: table of copy requests, scoreboarded memory writes.
module tb_mem_copy_engine;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] src_base, dst_base;
   logic [3:0]  count;
   logic        busy, done, memoryread, memorywrite;
   logic [31:0] address, write_data, read_data;

   mem_copy_engine #(.ADDR_W(32), .CNT_W(4), .STRIDE(8)) dut (
      .clk(clk), .reset(reset), .start(start),
      .src_base(src_base), .dst_base(dst_base), .count(count),
      .busy(busy), .done(done), .address(address), .write_data(write_data),
      .memoryread(memoryread), .memorywrite(memorywrite), .read_data(read_data)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [16];
   logic [31:0] model_mem [16];
   always_comb read_data = mem[address[6:3]];

   int errors = 0;
   int checks = 0;

   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   wr_t sb [$];

   typedef struct {
      logic [31:0] src;
      logic [31:0] dst;
      int          cnt;
      int          second_start;  // cycle carrying an ignored start, 0 = none
      int          rst_cycle;     // cycle with reset high, 0 = none
      int          exp_done;      // cycle with done high, 0 = never
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic init_mem();
      for (int i = 0; i < 16; i++) begin
         mem[i]       = (i < 8) ? 32'(i + 1) : 32'd0;
         model_mem[i] = mem[i];
      end
   endtask

   task automatic run_case(input vec_t v);
      int  last;
      logic exp_rd, exp_wr, exp_bz, exp_dn, in_rst;
      wr_t e;
      init_mem();
      sb.delete();
      // Forward-order reference copy: later words see earlier writes.
      for (int i = 0; i < v.cnt; i++) begin
         if (v.rst_cycle == 0 || 2 * i + 2 < v.rst_cycle) begin
            e.data = model_mem[((v.src >> 3) + 32'(i)) & 32'hF];
            e.addr = v.dst + 32'(8 * i);
            model_mem[e.addr[6:3]] = e.data;
            sb.push_back(e);
         end
      end
      last = (v.rst_cycle > 0) ? v.rst_cycle + 1 : 2 * v.cnt + 2;
      start    = 1'b1;
      src_base = v.src;
      dst_base = v.dst;
      count    = v.cnt[3:0];
      @(negedge clk);
      for (int k = 1; k <= last; k++) begin
         if (k > 1) @(negedge clk);
         in_rst = (v.rst_cycle > 0) && (k > v.rst_cycle);
         exp_rd = !in_rst && (k % 2 == 1) && (k <= 2 * v.cnt - 1);
         exp_wr = !in_rst && (k % 2 == 0) && (k <= 2 * v.cnt) && (k != v.rst_cycle);
         exp_bz = !in_rst && (k <= 2 * v.cnt + 1);
         exp_dn = (k == v.exp_done);
         chk($sformatf("memoryread c%0d", k), 32'(memoryread), 32'(exp_rd));
         chk($sformatf("memorywrite c%0d", k), 32'(memorywrite), 32'(exp_wr));
         chk($sformatf("done c%0d", k), 32'(done), 32'(exp_dn));
         if (k != v.rst_cycle) chk($sformatf("busy c%0d", k), 32'(busy), 32'(exp_bz));
         if (memoryread) begin
            chk($sformatf("rd_addr c%0d", k), address, v.src + 32'(8 * ((k - 1) / 2)));
         end
         if (memorywrite) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write c%0d: got addr %0h data %0h expected none",
                        k, address, write_data);
            end else begin
               e = sb.pop_front();
               chk($sformatf("wr_addr c%0d", k), address, e.addr);
               chk($sformatf("wr_data c%0d", k), write_data, e.data);
            end
            mem[address[6:3]] = write_data;
         end
         if (!memoryread && !memorywrite) begin
            chk($sformatf("idle_addr c%0d", k), address, 32'd0);
            chk($sformatf("idle_wdata c%0d", k), write_data, 32'd0);
         end
         start = (k + 1 == v.second_start);
         if (k + 1 == v.second_start) src_base = 32'd8;
         reset = (k + 1 == v.rst_cycle);
      end
      reset = 1'b0;
      start = 1'b0;
      chk("sb_empty", 32'(sb.size()), 32'd0);
      for (int i = 0; i < 16; i++) chk($sformatf("mem[%0d]", i * 8), mem[i], model_mem[i]);
   endtask

   vec_t vecs [7];

   initial begin
      vecs[0] = '{src: 32'd0,  dst: 32'd32, cnt: 4,  second_start: 0, rst_cycle: 0, exp_done: 9};
      vecs[1] = '{src: 32'd0,  dst: 32'd8,  cnt: 0,  second_start: 0, rst_cycle: 0, exp_done: 1};
      vecs[2] = '{src: 32'd0,  dst: 32'd32, cnt: 4,  second_start: 3, rst_cycle: 0, exp_done: 9};
      vecs[3] = '{src: 32'd0,  dst: 32'd8,  cnt: 3,  second_start: 0, rst_cycle: 0, exp_done: 7};
      vecs[4] = '{src: 32'd0,  dst: 32'd32, cnt: 4,  second_start: 0, rst_cycle: 6, exp_done: 0};
      vecs[5] = '{src: 32'd40, dst: 32'd0,  cnt: 5,  second_start: 0, rst_cycle: 0, exp_done: 11};
      vecs[6] = '{src: 32'd0,  dst: 32'd0,  cnt: 15, second_start: 0, rst_cycle: 0, exp_done: 31};

      reset    = 1'b1;
      start    = 1'b0;
      src_base = '0;
      dst_base = '0;
      count    = '0;
      init_mem();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (c == 3) begin
            chk("post_reset busy", 32'(busy), 32'd0);
         end else begin
            chk($sformatf("reset busy c%0d", c), 32'(busy), 32'd0);
            chk($sformatf("reset done c%0d", c), 32'(done), 32'd0);
            chk($sformatf("reset rd c%0d", c), 32'(memoryread), 32'd0);
            chk($sformatf("reset wr c%0d", c), 32'(memorywrite), 32'd0);
            chk($sformatf("reset addr c%0d", c), address, 32'd0);
            chk($sformatf("reset wdata c%0d", c), write_data, 32'd0);
         end
         if (c == 2) reset = 1'b0;
      end

      for (int t = 0; t < 7; t++) begin
         run_case(vecs[t]);
         @(negedge clk);
      end

      // Hand-checked overlap result: first word replicated forward.
      run_case(vecs[3]);
      chk("overlap w0", mem[0], 32'd1);
      chk("overlap w8", mem[1], 32'd1);
      chk("overlap w16", mem[2], 32'd1);
      chk("overlap w24", mem[3], 32'd1);
      chk("overlap w32", mem[4], 32'd5);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
